decode_stage: RTL and testbench

//  Registered, parametrised instruction-decode pipeline stage for picoMIPS; sits between fetch and execute.

---
 rtl/picomips_pkg.sv | 38 +++
 rtl/reg_scoreboard.sv | 62 ++++++
 rtl/decode_stage.sv | 210 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/picomips_pkg.sv
// picomips_pkg: shared types for the picoMIPS decode stage.
//   opcode_e : 4-bit opcode encoding of the picoMIPS instruction set
//   ctrl_t   : decoded control bundle handed to execute
//   ALU_ADD / ALU_MUL : alu_op encodings
package picomips_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_MUL   = 4'h1,
    OP_IN    = 4'h2,
    OP_OUT   = 4'h3,
    OP_LOADW = 4'h4,
    OP_ADDI  = 4'hB,
    OP_HALT  = 4'hC,
    OP_LOADI = 4'hE,
    OP_MOVE  = 4'hF
  } opcode_e;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_MUL = 2'd1;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_write;
    logic       use_imm;
    logic       use_rs_read2;
    logic       is_input;
    logic       is_output;
    logic       is_loadw;
    logic       is_loadi;
    logic       is_move;
    logic       is_addi;
  } ctrl_t;

  // All-zero control word: HALT, undefined opcodes and reset value.
  localparam ctrl_t CTRL_NOP = ctrl_t'(11'd0);

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: one pending bit per architectural register.
//   clk, n_reset        : clock, async active-low reset (clears all pending bits)
//   set_en / set_addr   : mark a register as having a write in flight
//   clr_en / clr_addr   : writeback retires a register (set wins on same reg)
//   rd_addr0..2         : query addresses
//   pend0..2            : registered pending state of each queried register
module reg_scoreboard #(
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] rd_addr0,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic              pend0,
  output logic              pend1,
  output logic              pend2
);

  localparam int unsigned NREG = 2 ** REG_AW;

  logic [NREG-1:0] pend_r;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] clr_mask_s;
  logic [NREG-1:0] pend_nxt_s;

  // One-hot set/clear masks; the OR after the clear makes set win over clear.
  always_comb begin
    set_mask_s = {NREG{1'b0}};
    clr_mask_s = {NREG{1'b0}};
    if (set_en) begin
      set_mask_s[set_addr] = 1'b1;
    end else begin
      set_mask_s = {NREG{1'b0}};
    end
    if (clr_en) begin
      clr_mask_s[clr_addr] = 1'b1;
    end else begin
      clr_mask_s = {NREG{1'b0}};
    end
    pend_nxt_s = (pend_r & ~clr_mask_s) | set_mask_s;
  end

  // Pending-bit register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pend_r <= {NREG{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // Queries see the registered state only; no writeback bypass.
  assign pend0 = pend_r[rd_addr0];
  assign pend1 = pend_r[rd_addr1];
  assign pend2 = pend_r[rd_addr2];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered picoMIPS instruction-decode stage between fetch
// and execute, with valid/ready handshake, RAW/WAW scoreboard stall and a
// sticky halt.
//   clk, n_reset               : clock, async active-low reset
//   in_valid/in_ready/instruction : fetch side handshake and word
//   wb_valid/wb_rd             : writeback retiring a register write
//   out_valid/out_ready        : execute side handshake
//   out_opcode/out_rd/out_rs/out_imm/out_ctrl : registered decoded bundle
//   stall                      : instruction present but blocked by a hazard
//   halted                     : sticky, set the cycle after HALT is accepted
//   illegal                    : sticky illegal-opcode flag
// Build option ILLEGAL_TRAP_EN: undefined opcodes are swallowed and set
// illegal and halted; otherwise they pass through as NOPs and illegal stays 0.
module decode_stage
  import picomips_pkg::*;
#(
  parameter int unsigned IW       = 16,
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned IMM_W    = 8,
  parameter int unsigned WAVE_REG = 2
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IW-1:0]     instruction,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_opcode,
  output logic [REG_AW-1:0] out_rd,
  output logic [REG_AW-1:0] out_rs,
  output logic [IMM_W-1:0]  out_imm,
  output ctrl_t             out_ctrl,
  output logic              stall,
  output logic              halted,
  output logic              illegal
);

`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  localparam logic [REG_AW-1:0] WAVE_ADDR = REG_AW'(WAVE_REG);

  opcode_e           opcode_s;
  logic [REG_AW-1:0] rd_f_s, rs_f_s, dec_rd_s, dec_rs_s;
  logic [IMM_W-1:0]  imm_f_s, dec_imm_s;
  ctrl_t             dec_ctrl_s;
  logic              rd_read_s, rs_read_s, wave_read_s, is_halt_s, is_undef_s;
  logic              rd_pend_s, rs_pend_s, wave_pend_s;
  logic              hazard_s, accept_s, trap_s, sb_set_s;

  logic              out_valid_r, halted_r, illegal_r;
  logic [3:0]        out_opcode_r;
  logic [REG_AW-1:0] out_rd_r, out_rs_r;
  logic [IMM_W-1:0]  out_imm_r;
  ctrl_t             out_ctrl_r;

  assign opcode_s = opcode_e'(instruction[IW-1 -: 4]);
  assign rd_f_s   = instruction[IW-5 -: REG_AW];
  assign rs_f_s   = instruction[IW-5-REG_AW -: REG_AW];
  assign imm_f_s  = instruction[IMM_W-1:0];

  // Opcode decode: fields a given opcode does not use are forced to zero.
  always_comb begin
    dec_ctrl_s  = CTRL_NOP;
    dec_rd_s    = {REG_AW{1'b0}};
    dec_rs_s    = {REG_AW{1'b0}};
    dec_imm_s   = {IMM_W{1'b0}};
    rd_read_s   = 1'b0;
    rs_read_s   = 1'b0;
    wave_read_s = 1'b0;
    is_halt_s   = 1'b0;
    is_undef_s  = 1'b0;
    case (opcode_s)
      OP_ADD, OP_MUL: begin
        dec_ctrl_s.alu_op       = (opcode_s == OP_MUL) ? ALU_MUL : ALU_ADD;
        dec_ctrl_s.reg_write    = 1'b1;
        dec_ctrl_s.use_rs_read2 = 1'b1;
        dec_rd_s  = rd_f_s;
        dec_rs_s  = rs_f_s;
        rd_read_s = 1'b1;
        rs_read_s = 1'b1;
      end
      OP_IN: begin
        dec_ctrl_s.reg_write = 1'b1;
        dec_ctrl_s.is_input  = 1'b1;
        dec_rd_s = rd_f_s;
      end
      OP_OUT: begin
        dec_ctrl_s.is_output = 1'b1;
        dec_rd_s  = rd_f_s;
        rd_read_s = 1'b1;
      end
      OP_LOADW: begin
        dec_ctrl_s.reg_write = 1'b1;
        dec_ctrl_s.is_loadw  = 1'b1;
        dec_rd_s    = rd_f_s;
        dec_rs_s    = WAVE_ADDR;
        wave_read_s = 1'b1;
      end
      OP_ADDI: begin
        dec_ctrl_s.alu_op    = ALU_ADD;
        dec_ctrl_s.reg_write = 1'b1;
        dec_ctrl_s.use_imm   = 1'b1;
        dec_ctrl_s.is_addi   = 1'b1;
        dec_rd_s  = rd_f_s;
        dec_imm_s = imm_f_s;
        rd_read_s = 1'b1;
      end
      OP_LOADI: begin
        dec_ctrl_s.reg_write = 1'b1;
        dec_ctrl_s.use_imm   = 1'b1;
        dec_ctrl_s.is_loadi  = 1'b1;
        dec_rd_s  = rd_f_s;
        dec_imm_s = imm_f_s;
      end
      OP_MOVE: begin
        dec_ctrl_s.reg_write = 1'b1;
        dec_ctrl_s.is_move   = 1'b1;
        dec_rd_s  = rd_f_s;
        dec_rs_s  = rs_f_s;
        rs_read_s = 1'b1;
      end
      OP_HALT: begin
        is_halt_s = 1'b1;
      end
      default: begin
        is_undef_s = 1'b1;
      end
    endcase
  end

  reg_scoreboard #(.REG_AW(REG_AW)) u_sb (
    .clk      (clk),
    .n_reset  (n_reset),
    .set_en   (sb_set_s),
    .set_addr (dec_rd_s),
    .clr_en   (wb_valid),
    .clr_addr (wb_rd),
    .rd_addr0 (rd_f_s),
    .rd_addr1 (rs_f_s),
    .rd_addr2 (WAVE_ADDR),
    .pend0    (rd_pend_s),
    .pend1    (rs_pend_s),
    .pend2    (wave_pend_s)
  );

  // rd pending blocks both a read of rd (RAW) and a second write to it (WAW).
  assign hazard_s = in_valid & (((rd_read_s | dec_ctrl_s.reg_write) & rd_pend_s) |
                                (rs_read_s & rs_pend_s) |
                                (wave_read_s & wave_pend_s));
  assign in_ready = ~halted_r & ~hazard_s & (~out_valid_r | out_ready);
  assign stall    = in_valid & ~halted_r & hazard_s;
  assign accept_s = in_valid & in_ready;
  assign trap_s   = TRAP_EN & is_undef_s;
  assign sb_set_s = accept_s & ~trap_s & dec_ctrl_s.reg_write;

  // Output bundle register: load on accept, drop valid after a consume.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      out_valid_r  <= 1'b0;
      out_opcode_r <= 4'd0;
      out_rd_r     <= {REG_AW{1'b0}};
      out_rs_r     <= {REG_AW{1'b0}};
      out_imm_r    <= {IMM_W{1'b0}};
      out_ctrl_r   <= CTRL_NOP;
    end else if (accept_s && !trap_s) begin
      out_valid_r  <= 1'b1;
      out_opcode_r <= opcode_s;
      out_rd_r     <= dec_rd_s;
      out_rs_r     <= dec_rs_s;
      out_imm_r    <= dec_imm_s;
      out_ctrl_r   <= dec_ctrl_s;
    end else if (out_ready) begin
      out_valid_r  <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_r;
    end
  end

  // Sticky halt/illegal flags; only reset clears them.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      halted_r  <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      if (accept_s && (is_halt_s || trap_s)) begin
        halted_r <= 1'b1;
      end
      if (accept_s && trap_s) begin
        illegal_r <= 1'b1;
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign out_opcode = out_opcode_r;
  assign out_rd     = out_rd_r;
  assign out_rs     = out_rs_r;
  assign out_imm    = out_imm_r;
  assign out_ctrl   = out_ctrl_r;
  assign halted     = halted_r;
  assign illegal    = illegal_r;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage (IW=16, REG_AW=3, IMM_W=8): directed steps
// followed by random traffic, all checked against a behavioural model.
module tb_decode_stage;
  import picomips_pkg::*;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0, n_reset = 1'b0;
  logic        in_valid = 1'b0, wb_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic [2:0]  wb_rd = 3'd0;
  logic        in_ready, out_valid, stall, halted, illegal;
  logic [3:0]  out_opcode;
  logic [2:0]  out_rd, out_rs;
  logic [7:0]  out_imm;
  ctrl_t       out_ctrl;
  logic [10:0] ctrl_bits;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0]  m_sb;
  logic        m_valid, m_halted, m_illegal;
  logic [3:0]  m_op;
  logic [2:0]  m_rd, m_rs;
  logic [7:0]  m_imm;
  logic [10:0] m_ctrl;

  decode_stage dut (
    .clk(clk), .n_reset(n_reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_rs(out_rs), .out_imm(out_imm), .out_ctrl(out_ctrl),
    .stall(stall), .halted(halted), .illegal(illegal)
  );

  assign ctrl_bits = out_ctrl;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Table-driven decode. ctrl bit order:
  // alu_op[1:0] reg_write use_imm use_rs_read2 is_input is_output is_loadw is_loadi is_move is_addi
  task automatic ref_decode(input logic [15:0] ins,
                            output logic [3:0] op, output logic [2:0] rd, output logic [2:0] rs,
                            output logic [7:0] imm, output logic [10:0] ctrl,
                            output logic [7:0] rmask, output logic wr,
                            output logic hlt, output logic und);
    logic [2:0] rdf, rsf;
    rdf = ins[11:9];
    rsf = ins[8:6];
    op = ins[15:12];
    rd = 3'd0; rs = 3'd0; imm = 8'd0; ctrl = 11'd0; rmask = 8'd0;
    wr = 1'b0; hlt = 1'b0; und = 1'b0;
    case (op)
      4'h0: begin rd = rdf; rs = rsf; ctrl = 11'b00_1_0_1_000000; rmask = (8'd1 << rdf) | (8'd1 << rsf); end
      4'h1: begin rd = rdf; rs = rsf; ctrl = 11'b01_1_0_1_000000; rmask = (8'd1 << rdf) | (8'd1 << rsf); end
      4'h2: begin rd = rdf; ctrl = 11'b00_1_0_0_100000; end
      4'h3: begin rd = rdf; ctrl = 11'b00_0_0_0_010000; rmask = 8'd1 << rdf; end
      4'h4: begin rd = rdf; rs = 3'd2; ctrl = 11'b00_1_0_0_001000; rmask = 8'd1 << 2; end
      4'hB: begin rd = rdf; imm = ins[7:0]; ctrl = 11'b00_1_1_0_000001; rmask = 8'd1 << rdf; end
      4'hE: begin rd = rdf; imm = ins[7:0]; ctrl = 11'b00_1_1_0_000100; end
      4'hF: begin rd = rdf; rs = rsf; ctrl = 11'b00_1_0_0_000010; rmask = 8'd1 << rsf; end
      4'hC: hlt = 1'b1;
      default: und = 1'b1;
    endcase
    wr = ctrl[8];
  endtask

  task automatic m_reset();
    m_sb = 8'd0; m_valid = 1'b0; m_halted = 1'b0; m_illegal = 1'b0;
    m_op = 4'd0; m_rd = 3'd0; m_rs = 3'd0; m_imm = 8'd0; m_ctrl = 11'd0;
  endtask

  // One clock: check everything at the falling edge, then advance the model.
  task automatic cycle();
    logic [3:0] op; logic [2:0] rd, rs; logic [7:0] imm, rmask, nsb; logic [10:0] ctrl;
    logic wr, hlt, und, haz, ready_e, stall_e, acc, trp;
    @(negedge clk);
    ref_decode(instruction, op, rd, rs, imm, ctrl, rmask, wr, hlt, und);
    haz     = in_valid && (((rmask | (wr ? (8'd1 << rd) : 8'd0)) & m_sb) != 8'd0);
    ready_e = !m_halted && !haz && (!m_valid || out_ready);
    stall_e = in_valid && !m_halted && haz;
    chk("in_ready",   {31'd0, in_ready},   {31'd0, ready_e});
    chk("stall",      {31'd0, stall},      {31'd0, stall_e});
    chk("out_valid",  {31'd0, out_valid},  {31'd0, m_valid});
    chk("halted",     {31'd0, halted},     {31'd0, m_halted});
    chk("illegal",    {31'd0, illegal},    {31'd0, m_illegal});
    chk("out_opcode", {28'd0, out_opcode}, {28'd0, m_op});
    chk("out_rd",     {29'd0, out_rd},     {29'd0, m_rd});
    chk("out_rs",     {29'd0, out_rs},     {29'd0, m_rs});
    chk("out_imm",    {24'd0, out_imm},    {24'd0, m_imm});
    chk("out_ctrl",   {21'd0, ctrl_bits},  {21'd0, m_ctrl});
    @(posedge clk);
    acc = in_valid && ready_e;
    trp = TRAP && und;
    nsb = m_sb;
    if (wb_valid) nsb[wb_rd] = 1'b0;
    if (acc && wr && !trp) nsb[rd] = 1'b1;
    m_sb = nsb;
    if (acc && !trp) begin
      m_valid = 1'b1; m_op = op; m_rd = rd; m_rs = rs; m_imm = imm; m_ctrl = ctrl;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (acc && (hlt || trp)) m_halted = 1'b1;
    if (acc && trp) m_illegal = 1'b1;
    #1;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] ops [8];
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hE, 4'hF};
    return {ops[$urandom_range(0, 7)], 12'($urandom)};
  endfunction

  initial begin
    // 1: reset state
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_halted",    {31'd0, halted},    32'd0);
    chk("rst_stall",     {31'd0, stall},     32'd0);
    chk("rst_ctrl",      {21'd0, ctrl_bits}, 32'd0);
    n_reset = 1'b1;
    cycle();

    // 2: LOADI R3,0x5A
    in_valid = 1'b1; instruction = 16'hE65A; out_ready = 1'b1;
    cycle();
    chk("loadi_valid", {31'd0, out_valid}, 32'd1);
    chk("loadi_rd",    {29'd0, out_rd},    32'd3);
    chk("loadi_imm",   {24'd0, out_imm},   32'h5A);
    chk("loadi_ctrl",  {21'd0, ctrl_bits}, {21'd0, 11'b00_1_1_0_000100});

    // 3: ADDI R3,1 stalls on R3 until writeback retires it
    instruction = 16'hB601;
    cycle();
    chk("raw_stall", {31'd0, stall},    32'd1);
    chk("raw_ready", {31'd0, in_ready}, 32'd0);
    wb_valid = 1'b1; wb_rd = 3'd3;
    cycle();
    wb_valid = 1'b0;
    cycle();
    chk("addi_valid", {31'd0, out_valid},    32'd1);
    chk("addi_imm",   {24'd0, out_imm},      32'h01);
    chk("addi_flag",  {31'd0, ctrl_bits[0]}, 32'd1);

    // 4: ADD R1,R2 held while execute back-pressures
    instruction = 16'h0280;
    cycle();
    out_ready = 1'b0; instruction = 16'hEA11;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_rd",    {29'd0, out_rd},          32'd1);
      chk("hold_rs",    {29'd0, out_rs},          32'd2);
      chk("hold_alu",   {30'd0, ctrl_bits[10:9]}, 32'd0);
      chk("hold_ready", {31'd0, in_ready},        32'd0);
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();

    // 5: HALT, then reset clears it
    in_valid = 1'b1; instruction = 16'hC000;
    cycle();
    chk("halt_set", {31'd0, halted}, 32'd1);
    instruction = 16'hE100;
    cycle();
    chk("halt_ready", {31'd0, in_ready}, 32'd0);
    n_reset = 1'b0;
    #2;
    chk("rst2_halted", {31'd0, halted},    32'd0);
    chk("rst2_valid",  {31'd0, out_valid}, 32'd0);
    m_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_reset = 1'b1;

    // Random traffic with writebacks and back-pressure
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      instruction = rand_instr();
      out_ready   = ($urandom_range(0, 4) > 1);
      wb_valid    = $urandom_range(0, 1) == 1;
      wb_rd       = 3'($urandom_range(0, 7));
      cycle();
    end

    // 6: undefined opcode
    in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b0;
    cycle();
    cycle();
    in_valid = 1'b1; instruction = 16'h5000;
    cycle();
    in_valid = 1'b0;
    if (TRAP) begin
      chk("undef_illegal", {31'd0, illegal},   32'd1);
      chk("undef_halted",  {31'd0, halted},    32'd1);
      chk("undef_valid",   {31'd0, out_valid}, 32'd0);
    end else begin
      chk("undef_illegal", {31'd0, illegal},   32'd0);
      chk("undef_valid",   {31'd0, out_valid}, 32'd1);
      chk("undef_ctrl",    {21'd0, ctrl_bits}, 32'd0);
    end
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
